led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 47 ++++
 rtl/led_pattern_gen.sv | 116 +++++++++++
 tb/tb_led_pattern_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    ROTATE_L = 2'd0,
    ROTATE_R = 2'd1,
    BOUNCE   = 2'd2,
    BINARY   = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_t;

  localparam int unsigned CLK_FREQ_HZ = 32'd100000000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: counts 0..TICK_CYCLES-1 and strobes on the wrap edge.
module tick_prescaler
  import led_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over counting, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign strobe = enable & ~clear & (cnt_q == LAST);

  // Count register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate left/right, bounce and binary count, one step per prescaler wrap.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LED       = 8,
  parameter int unsigned TICK_CYCLES = CLK_FREQ_HZ
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             PAUSE,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  localparam int unsigned PW = $clog2(N_LED);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
  localparam logic [N_LED-1:0] LED_FIRST = {{(N_LED-1){1'b0}}, 1'b1};

  function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
    return LED_FIRST << p;
  endfunction

  led_mode_t        mode_in;
  logic             mode_change;
  logic             step;
  led_mode_t        mode_q, mode_d;
  led_dir_t         dir_q, dir_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [N_LED-1:0] cnt_q, cnt_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             tick_q, tick_d;

  assign mode_in     = led_mode_t'(MODE);
  assign mode_change = (mode_in != mode_q);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .clear (mode_change),
    .enable(~PAUSE),
    .strobe(step)
  );

  // Next pattern state: mode change beats pause, pause beats step.
  always_comb begin
    mode_d = mode_in;
    dir_d  = dir_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    tick_d = 1'b0;
    if (mode_change) begin
      dir_d = DIR_UP;
      pos_d = '0;
      cnt_d = '0;
      led_d = (mode_in == BINARY) ? {N_LED{1'b0}} : LED_FIRST;
    end else if (PAUSE) begin
      tick_d = 1'b0;
    end else if (step) begin
      tick_d = 1'b1;
      case (mode_q)
        ROTATE_L: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        ROTATE_R: pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
        BOUNCE: begin
          // Turn around at the ends so each end LED shows only once per sweep.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = pos_q - PW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        BINARY:   cnt_d = cnt_q + LED_FIRST;
        default:  pos_d = pos_q;
      endcase
      led_d = (mode_q == BINARY) ? cnt_d : onehot(pos_d);
    end else begin
      tick_d = 1'b0;
    end
  end

  // Pattern state and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= ROTATE_L;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      cnt_q  <= '0;
      led_q  <= LED_FIRST;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (N_LED=8, TICK_CYCLES=4) against a behavioural model.
module tb_led_pattern_gen;

  localparam int N  = 8;
  localparam int TC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] led;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .N_LED      (N),
    .TICK_CYCLES(TC)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .MODE (mode),
    .PAUSE(pause),
    .LED  (led),
    .TICK (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb_q[$];

  // Behavioural model state; bounce tracked as a position along a 2N-2 step sweep.
  int m_presc, m_pos, m_sweep, m_cnt, m_mode;
  logic [7:0] m_led;
  logic m_tick;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bounce_pos(input int s);
    return (s < N) ? s : (2 * N - 2 - s);
  endfunction

  task automatic model_edge(input bit r, input int md, input bit p);
    m_tick = 1'b0;
    if (r) begin
      m_presc = 0; m_pos = 0; m_sweep = 0; m_cnt = 0; m_mode = 0;
    end else if (md != m_mode) begin
      m_mode = md; m_presc = 0; m_pos = 0; m_sweep = 0; m_cnt = 0;
    end else if (!p) begin
      if (m_presc == TC - 1) begin
        m_presc = 0;
        m_tick  = 1'b1;
        case (m_mode)
          0:       m_pos = (m_pos + 1) % N;
          1:       m_pos = (m_pos + N - 1) % N;
          2:       m_sweep = (m_sweep + 1) % (2 * N - 2);
          default: m_cnt = (m_cnt + 1) % (1 << N);
        endcase
      end else begin
        m_presc++;
      end
    end
    case (m_mode)
      0, 1:    m_led = 8'(1 << m_pos);
      2:       m_led = 8'(1 << bounce_pos(m_sweep));
      default: m_led = 8'(m_cnt);
    endcase
  endtask

  task automatic cycle(input bit r, input int md, input bit p, input string tag);
    logic [8:0] e;
    @(negedge clk);
    rst   = r;
    mode  = 2'(md);
    pause = p;
    model_edge(r, md, p);
    sb_q.push_back({m_led, m_tick});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".led"}, 32'(led), 32'(e[8:1]));
    check_eq({tag, ".tick"}, 32'(tick), 32'(e[0]));
  endtask

  initial begin
    int rmode;
    bit rpause;
    bit rrst;
    rst = 1'b1; mode = 2'd0; pause = 1'b0;

    cycle(1'b1, 0, 1'b0, "rst");
    check_eq("rst_led", 32'(led), 32'h01);
    repeat (32) cycle(1'b0, 0, 1'b0, "rotl");
    check_eq("rotl_wrap", 32'(led), 32'h01);
    repeat (8) cycle(1'b0, 0, 1'b0, "rotl");

    cycle(1'b1, 1, 1'b0, "rst_m1");
    cycle(1'b0, 1, 1'b0, "m1_change");
    check_eq("m1_change_tick", 32'(tick), 32'h0);
    repeat (4) cycle(1'b0, 1, 1'b0, "rotr");
    check_eq("rotr_first", 32'(led), 32'h80);
    repeat (36) cycle(1'b0, 1, 1'b0, "rotr");

    cycle(1'b0, 2, 1'b0, "m2_change");
    repeat (4 * 30) cycle(1'b0, 2, 1'b0, "bounce");

    cycle(1'b0, 3, 1'b0, "m3_change");
    repeat (1023) cycle(1'b0, 3, 1'b0, "bin");
    check_eq("bin_ff", 32'(led), 32'hff);
    cycle(1'b0, 3, 1'b0, "bin");
    check_eq("bin_wrap", 32'(led), 32'h00);

    cycle(1'b0, 0, 1'b0, "m0_change");
    for (int k = 0; k < 8 && m_presc != 2; k++) cycle(1'b0, 0, 1'b0, "pre_pause");
    repeat (10) cycle(1'b0, 0, 1'b1, "pause");
    cycle(1'b0, 0, 1'b0, "release1");
    check_eq("release1_tick", 32'(tick), 32'h0);
    cycle(1'b0, 0, 1'b0, "release2");
    check_eq("release2_tick", 32'(tick), 32'h1);

    for (int k = 0; k < 8 && m_presc != 3; k++) cycle(1'b0, 0, 1'b0, "pre_mc");
    cycle(1'b0, 3, 1'b0, "mc_on_step");
    check_eq("mc_on_step_led", 32'(led), 32'h00);
    check_eq("mc_on_step_tick", 32'(tick), 32'h0);
    repeat (3) cycle(1'b0, 3, 1'b0, "mc_wait");
    cycle(1'b0, 3, 1'b0, "mc_next");
    check_eq("mc_next_tick", 32'(tick), 32'h1);
    check_eq("mc_next_led", 32'(led), 32'h01);

    for (int k = 0; k < 8 && m_presc != 3; k++) cycle(1'b0, 3, 1'b0, "pre_rst");
    cycle(1'b1, 3, 1'b0, "rst_on_step");
    check_eq("rst_on_step_led", 32'(led), 32'h01);
    check_eq("rst_on_step_tick", 32'(tick), 32'h0);
    cycle(1'b0, 3, 1'b0, "post_rst_mc");

    rmode = 3;
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) rmode = int'($urandom_range(0, 3));
      rpause = ($urandom_range(0, 4) == 0);
      rrst   = ($urandom_range(0, 199) == 0);
      cycle(rrst, rmode, rpause, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
